// File: rtl/sevenseg_scan_if.sv
// Display-side bundle between the stopwatch core and the 7-segment scan stage.
// The master drives digit codes and masks; the slave drives anodes and segments.
interface sevenseg_scan_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] blank_mask;
  logic [3:0] blink_mask;
  logic       blink_en;
  logic [3:0] an;
  logic [7:0] seg;

  modport master (
    output digit0, digit1, digit2, digit3,
    output blank_mask, blink_mask, blink_en,
    input  an, seg
  );

  modport slave (
    input  digit0, digit1, digit2, digit3,
    input  blank_mask, blink_mask, blink_en,
    output an, seg
  );
endinterface

// File: rtl/sevenseg_scan.sv
// Four-digit common-anode 7-segment scanner with a per-slot guard interval,
// per-digit blanking and blinking. Digit code and darkness are latched once per slot.
module sevenseg_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 1000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic           clk,
  input  logic           reset,
  sevenseg_scan_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  // S_START only exists between reset release and the first edge, so a zero
  // guard still latches digit 0 on that first edge.
  typedef enum logic [1:0] {
    S_START,
    S_GUARD,
    S_DRIVE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       idx, idx_d;
  logic [BLK_W-1:0] bcnt, bcnt_d;
  logic             blink_on, blink_on_d;
  logic [3:0]       code, code_d;
  logic             dark, dark_d;
  logic [3:0]       an_d;
  logic [7:0]       seg_d;
  logic [3:0]       sel_code;
  logic             latch;

  function automatic logic [7:0] decode(input logic [3:0] c);
    logic [7:0] s;
    case (c)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: every combinational output is given a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d      = cnt + 1'b1;
    idx_d      = idx;
    bcnt_d     = bcnt + 1'b1;
    blink_on_d = blink_on;
    code_d     = code;
    dark_d     = dark;
    an_d       = 4'hF;
    seg_d      = 8'hFF;
    sel_code   = bus.digit0;

    if (cnt == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx + 2'd1;
    end

    if (!bus.blink_en) begin
      bcnt_d     = '0;
      blink_on_d = 1'b1;
    end else if (bcnt == BLK_MAX) begin
      bcnt_d     = '0;
      blink_on_d = ~blink_on;
    end

    state_d = ((GUARD != 0) && (cnt_d < GUARD_C)) ? S_GUARD : S_DRIVE;
    latch   = (cnt_d == GUARD_C) || ((GUARD == 0) && (state == S_START));

    case (idx_d)
      2'd0:    sel_code = bus.digit0;
      2'd1:    sel_code = bus.digit1;
      2'd2:    sel_code = bus.digit2;
      default: sel_code = bus.digit3;
    endcase

    // The blink phase used is the one in force just before the latch edge.
    if (latch) begin
      code_d = sel_code;
      dark_d = bus.blank_mask[idx_d]
             | (bus.blink_en & bus.blink_mask[idx_d] & ~blink_on);
    end

    if (state_d == S_DRIVE && !dark_d) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = decode(code_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_START;
      cnt      <= '0;
      idx      <= 2'd0;
      bcnt     <= '0;
      blink_on <= 1'b1;
      code     <= 4'd0;
      dark     <= 1'b1;
      bus.an   <= 4'hF;
      bus.seg  <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      bcnt     <= bcnt_d;
      blink_on <= blink_on_d;
      code     <= code_d;
      dark     <= dark_d;
      bus.an   <= an_d;
      bus.seg  <= seg_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: two instances (GUARD=1 and GUARD=0) driven with the same inputs,
// checked against a timeline model built from per-edge input history.
module tb_sevenseg_scan;

  localparam int R    = 4;
  localparam int B    = 8;
  localparam int MAXT = 4096;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sevenseg_scan_if a_if ();
  sevenseg_scan_if b_if ();

  sevenseg_scan #(.REFRESH_DIV(R), .GUARD(1), .BLINK_DIV(B)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  sevenseg_scan #(.REFRESH_DIV(R), .GUARD(0), .BLINK_DIV(B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t      = 0;

  logic [3:0] dig [4];
  logic [3:0] blank;
  logic [3:0] bmask;
  logic       en;

  logic [3:0] h_dig   [MAXT][4];
  logic [3:0] h_blank [MAXT];
  logic [3:0] h_bm    [MAXT];
  logic       h_en    [MAXT];

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_ref(input logic [3:0] c);
    case (c)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected {an,seg} after edge number te since reset release, for a given guard length.
  function automatic logic [11:0] model(input int guard, input int te);
    int slot, cnt, idx, l, run;
    bit on, dark;
    logic [3:0] code;
    if (te == 0) return 12'hFFF;
    slot = te / R;
    cnt  = te % R;
    idx  = slot % 4;
    if (cnt < guard) return 12'hFFF;
    l = slot * R + guard;
    if (l == 0) l = 1;
    run = 0;
    for (int k = l - 1; k >= 1; k--) begin
      if (!h_en[k]) break;
      run++;
    end
    on   = ((run / B) % 2) == 0;
    code = h_dig[l][idx];
    dark = h_blank[l][idx] | (h_en[l] & h_bm[l][idx] & !on);
    if (dark) return 12'hFFF;
    return {~(4'b0001 << idx), seg_ref(code)};
  endfunction

  task automatic apply();
    a_if.digit0 = dig[0]; a_if.digit1 = dig[1]; a_if.digit2 = dig[2]; a_if.digit3 = dig[3];
    b_if.digit0 = dig[0]; b_if.digit1 = dig[1]; b_if.digit2 = dig[2]; b_if.digit3 = dig[3];
    a_if.blank_mask = blank; a_if.blink_mask = bmask; a_if.blink_en = en;
    b_if.blank_mask = blank; b_if.blink_mask = bmask; b_if.blink_en = en;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      apply();
      for (int j = 0; j < 4; j++) h_dig[t+1][j] = dig[j];
      h_blank[t+1] = blank;
      h_bm[t+1]    = bmask;
      h_en[t+1]    = en;
      @(posedge clk);
      t++;
      #1;
      check("model_g1", {a_if.an, a_if.seg}, model(1, t));
      check("model_g0", {b_if.an, b_if.seg}, model(0, t));
      check("onehot_a", {11'd0, $countones(~a_if.an) <= 1}, 12'd1);
      check("onehot_b", {11'd0, $countones(~b_if.an) <= 1}, 12'd1);
    end
  endtask

  // Entered just after a clock edge; asserts reset mid-cycle and releases it mid-cycle later.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_async_a", {a_if.an, a_if.seg}, 12'hFFF);
    check("rst_async_b", {b_if.an, b_if.seg}, 12'hFFF);
    @(posedge clk);
    #2 reset = 1'b0;
    t = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    dig[0] = 4'd7; dig[1] = 4'd3; dig[2] = 4'd2; dig[3] = 4'd1;
    blank = 4'b0000; bmask = 4'b0000; en = 1'b0;
    apply();
    @(posedge clk); #1;
    check("reset_a", {a_if.an, a_if.seg}, 12'hFFF);
    check("reset_b", {b_if.an, b_if.seg}, 12'hFFF);
    @(posedge clk);
    #2 reset = 1'b0;
    t = 0;

    // Scan order and guard gap
    step(1);  check("scan_e1",  {a_if.an, a_if.seg}, {4'b1110, 8'hF8});
    step(2);  check("scan_e3",  {a_if.an, a_if.seg}, {4'b1110, 8'hF8});
    step(1);  check("scan_e4",  {a_if.an, a_if.seg}, 12'hFFF);
              check("g0_e4",    {b_if.an, b_if.seg}, {4'b1101, 8'hB0});
    step(1);  check("scan_e5",  {a_if.an, a_if.seg}, {4'b1101, 8'hB0});
    step(4);  check("scan_e9",  {a_if.an, a_if.seg}, {4'b1011, 8'hA4});
    step(4);  check("scan_e13", {a_if.an, a_if.seg}, {4'b0111, 8'hF9});
    step(4);  check("scan_e17", {a_if.an, a_if.seg}, {4'b1110, 8'hF8});

    // Blanking, and a non-numeric code that still drives its anode
    blank = 4'b0100;
    step(16);
    dig[1] = 4'hC;
    step(16);
    blank = 4'b0000; dig[1] = 4'd3;

    // Blinking digit 0, then disabling blink during a dark phase
    en = 1'b1; bmask = 4'b0001;
    step(44);
    en = 1'b0;
    step(20);
    bmask = 4'b0000;

    // Mid-slot input change is ignored until the next latch of that digit
    do_reset();
    dig[0] = 4'd7;
    step(2);
    dig[0] = 4'd5;
    step(1);  check("midslot_e3",  {a_if.an, a_if.seg}, {4'b1110, 8'hF8});
    step(14); check("midslot_e17", {a_if.an, a_if.seg}, {4'b1110, 8'h92});

    // Reset in the middle of digit 1's slot
    do_reset();
    step(6);  check("pre_rst_e6", {a_if.an, a_if.seg}, {4'b1101, 8'hB0});
    do_reset();
    step(1);  check("post_rst_e1", {a_if.an, a_if.seg}, {4'b1110, 8'h92});

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0)
        for (int j = 0; j < 4; j++) dig[j] = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) blank = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) bmask = 4'($urandom_range(15));
      if ($urandom_range(31) == 0) en = ~en;
      if ($urandom_range(299) == 0 || t >= MAXT - 2) do_reset();
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
